decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 94 +++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Decode stage: instruction field decode, load-use hazard stall, writeback bypass
// and the ID/EX pipeline register with backpressure, bubble and flush handling.
module decode_stage #(
    parameter int WIDTH             = 16,
    parameter int LOG_NUM_REGISTERS = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         if_valid,
    input  logic [15:0]                  if_instr,
    output logic                         if_ready,
    output logic [LOG_NUM_REGISTERS-1:0] rf_ra,
    output logic [LOG_NUM_REGISTERS-1:0] rf_rb,
    input  logic [WIDTH-1:0]             rf_a,
    input  logic [WIDTH-1:0]             rf_b,
    input  logic                         wb_we,
    input  logic [LOG_NUM_REGISTERS-1:0] wb_addr,
    input  logic [WIDTH-1:0]             wb_data,
    input  logic                         ex_load_pending,
    input  logic [LOG_NUM_REGISTERS-1:0] ex_load_rd,
    input  logic                         ex_ready,
    input  logic                         flush,
    output logic                         id_valid,
    output logic [3:0]                   id_op,
    output logic [LOG_NUM_REGISTERS-1:0] id_rd,
    output logic                         id_we,
    output logic [WIDTH-1:0]             id_opa,
    output logic [WIDTH-1:0]             id_opb,
    output logic [15:0]                  stall_cnt
);
    localparam int L = LOG_NUM_REGISTERS;

    logic [3:0]       op;
    logic [L-1:0]     rd, ra, rb;
    logic [5:0]       imm6;
    logic             uses_ra, uses_rb, writes;
    logic             hazard, capture;
    logic [WIDTH-1:0] opa_next, opb_reg, opb_next;

    assign op   = if_instr[15:12];
    assign rd   = L'(if_instr[11:9]);
    assign ra   = L'(if_instr[8:6]);
    assign rb   = L'(if_instr[5:3]);
    assign imm6 = if_instr[5:0];

    assign rf_ra = ra;
    assign rf_rb = rb;

    // op 0 is a NOP; op[3] selects the sign-extended immediate instead of rb
    assign uses_ra = (op != 4'h0);
    assign uses_rb = (op != 4'h0) && !op[3];
    assign writes  = (op != 4'h0) && (op != 4'h7);

    assign hazard = if_valid && ex_load_pending &&
                    ((uses_ra && ex_load_rd == ra) || (uses_rb && ex_load_rd == rb));

    assign if_ready = flush || ((!id_valid || ex_ready) && !hazard);
    assign capture  = !flush && if_valid && if_ready;

    assign opa_next = (wb_we && wb_addr == ra) ? wb_data : rf_a;
    assign opb_reg  = (wb_we && wb_addr == rb) ? wb_data : rf_b;
    assign opb_next = op[3] ? WIDTH'($signed(imm6)) : opb_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid  <= 1'b0;
            id_we     <= 1'b0;
            id_op     <= '0;
            id_rd     <= '0;
            id_opa    <= '0;
            id_opb    <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                id_valid <= 1'b0;
                id_we    <= 1'b0;
            end else if (capture) begin
                id_valid <= 1'b1;
                id_op    <= op;
                id_rd    <= rd;
                id_opa   <= opa_next;
                id_opb   <= opb_next;
                id_we    <= writes;
            end else if (id_valid && ex_ready) begin
                // consumed downstream with nothing new: drop to a bubble, keep data
                id_valid <= 1'b0;
                id_we    <= 1'b0;
            end

            if (hazard && !flush && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule
